// File: rtl/pid_pkg.sv
// Shared definitions for the PID position controller: state encoding,
// fixed-point constants and a small magnitude helper.
package pid_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_CALC        = 4'd1,
      ST_UPDATE      = 4'd2,
      ST_WAIT_SAMPLE = 4'd3,
      ST_DONE        = 4'd4
   } state_t;

   // What the UPDATE state should do after publishing a new ratio.
   typedef enum logic [1:0] {
      OUT_CONTINUE = 2'd0,
      OUT_DONE     = 2'd1,
      OUT_STALL    = 2'd2
   } outcome_t;

   // Gains are fixed point with four fractional bits.
   localparam int GAIN_SHIFT = 4;

   // The accumulated error is clamped to this symmetric range.
   localparam logic signed [13:0] INTEGRAL_LIMIT = 14'sd2047;

   // Number of startup steps that are capped by the profile bytes.
   localparam logic [3:0] PROFILE_DEPTH = 4'd8;

   // Identical consecutive samples that count as a stalled motor.
   localparam logic [3:0] STALL_LIMIT = 4'd8;

   // Absolute value of a 14-bit signed quantity; every caller stays
   // within +/-8191, so the result always fits in 13 bits.
   function automatic logic [12:0] magnitude(input logic signed [13:0] value);
      logic signed [13:0] pos;
      pos = (value < 14'sd0) ? -value : value;
      return 13'(pos);
   endfunction

endpackage

// File: rtl/pid_term_calc.sv
// Gain datapath: scales the three error magnitudes by their fixed-point
// gains, sums the terms and saturates the result to an 8-bit duty ratio.
module pid_term_calc
   import pid_pkg::*;
(
   input  logic [7:0]  kp,
   input  logic [3:0]  ki,
   input  logic [3:0]  kd,
   input  logic [12:0] err_mag,
   input  logic [12:0] integ_mag,
   input  logic [12:0] delta_mag,
   output logic [7:0]  ratio
);

   logic [20:0] p_prod;
   logic [16:0] i_prod;
   logic [16:0] d_prod;
   logic [18:0] sum;

   // Multiply, drop the fractional bits of each term, add and clamp to 255.
   always_comb begin
      p_prod = 21'(kp) * 21'(err_mag);
      i_prod = 17'(ki) * 17'(integ_mag);
      d_prod = 17'(kd) * 17'(delta_mag);
      sum    = 19'(p_prod >> GAIN_SHIFT)
             + 19'(i_prod >> GAIN_SHIFT)
             + 19'(d_prod >> GAIN_SHIFT);
      ratio  = (sum > 19'd255) ? 8'hFF : sum[7:0];
   end

endmodule

// File: rtl/pid.sv
// PID angle controller: drives a PWM ratio/direction from the difference
// between a latched target angle and encoder samples, with a startup
// ratio profile, an optional stall detector and abort handling.
module pid
   import pid_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] target_angle,
   input  logic [11:0] current_angle,
   input  logic        pwm_enable,
   input  logic        pwm_done,
   input  logic        i2c_rd_done,
   input  logic        angle_update,
   input  logic        abort_angle,
   input  logic [63:0] profile,
   input  logic        enable_stall_chk,
   input  logic [7:0]  kp,
   input  logic [3:0]  ki,
   input  logic [3:0]  kd,
   output logic        startup_fail,
   output logic [15:0] debug_signals,
   output logic        angle_done,
   output logic        pwm_update,
   output logic [7:0]  pwm_ratio,
   output logic        pwm_direction
);

   state_t             state;
   outcome_t           outcome;
   logic [11:0]        target_latched;
   logic [11:0]        last_angle;
   logic signed [11:0] integral;
   logic signed [12:0] prev_err;
   logic [3:0]         step_idx;
   logic [3:0]         stall_cnt;

   logic signed [12:0] err;
   logic signed [13:0] integ_sum;
   logic signed [11:0] integ_next;
   logic signed [13:0] delta;
   logic [12:0]        err_mag;
   logic [12:0]        integ_mag;
   logic [12:0]        delta_mag;
   logic [7:0]         pid_out;
   logic [7:0]         profile_bytes [8];
   logic [7:0]         cap_byte;
   logic [7:0]         capped_ratio;
   logic               in_profile;
   logic [3:0]         stall_next;
   logic               stall_hit;

   // Split the profile word so that byte [63:56] is step 0.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         profile_bytes[i] = profile[63 - 8*i -: 8];
      end
   end

   // Error, clamped integral, derivative and their magnitudes for this sample.
   always_comb begin
      err       = $signed({1'b0, target_latched}) - $signed({1'b0, current_angle});
      integ_sum = 14'(integral) + 14'(err);
      if (integ_sum > INTEGRAL_LIMIT) begin
         integ_next = 12'(INTEGRAL_LIMIT);
      end else if (integ_sum < -INTEGRAL_LIMIT) begin
         integ_next = 12'(-INTEGRAL_LIMIT);
      end else begin
         integ_next = integ_sum[11:0];
      end
      delta     = 14'(err) - 14'(prev_err);
      err_mag   = magnitude(14'(err));
      integ_mag = magnitude(14'(integ_next));
      delta_mag = magnitude(delta);
   end

   pid_term_calc u_term_calc (
      .kp        (kp),
      .ki        (ki),
      .kd        (kd),
      .err_mag   (err_mag),
      .integ_mag (integ_mag),
      .delta_mag (delta_mag),
      .ratio     (pid_out)
   );

   // Startup cap and stall run length; the first sample of a move starts a new run.
   always_comb begin
      in_profile   = (step_idx < PROFILE_DEPTH);
      cap_byte     = profile_bytes[step_idx[2:0]];
      capped_ratio = (in_profile && (pid_out > cap_byte)) ? cap_byte : pid_out;
      if (step_idx == 4'd0 || current_angle != last_angle) begin
         stall_next = 4'd1;
      end else if (stall_cnt == STALL_LIMIT) begin
         stall_next = STALL_LIMIT;
      end else begin
         stall_next = stall_cnt + 4'd1;
      end
      stall_hit = enable_stall_chk && in_profile && (stall_next == STALL_LIMIT);
   end

   // Controller state machine; abort and loss of enable override every active state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         outcome        <= OUT_CONTINUE;
         target_latched <= 12'd0;
         last_angle     <= 12'd0;
         integral       <= 12'sd0;
         prev_err       <= 13'sd0;
         step_idx       <= 4'd0;
         stall_cnt      <= 4'd0;
         startup_fail   <= 1'b0;
         pwm_ratio      <= 8'd0;
         pwm_direction  <= 1'b0;
         pwm_update     <= 1'b0;
         angle_done     <= 1'b0;
      end else begin
         pwm_update <= 1'b0;
         angle_done <= 1'b0;
         if (state != ST_IDLE && (abort_angle || !pwm_enable)) begin
            pwm_ratio  <= 8'd0;
            pwm_update <= 1'b1;
            state      <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (angle_update && pwm_enable) begin
                     target_latched <= target_angle;
                     integral       <= 12'sd0;
                     prev_err       <= 13'sd0;
                     step_idx       <= 4'd0;
                     stall_cnt      <= 4'd0;
                     startup_fail   <= 1'b0;
                     state          <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  prev_err      <= err;
                  integral      <= integ_next;
                  last_angle    <= current_angle;
                  stall_cnt     <= stall_next;
                  pwm_direction <= (err > 13'sd0);
                  if (in_profile) begin
                     step_idx <= step_idx + 4'd1;
                  end
                  if (err == 13'sd0) begin
                     pwm_ratio <= 8'd0;
                     outcome   <= OUT_DONE;
                  end else if (stall_hit) begin
                     pwm_ratio    <= 8'd0;
                     startup_fail <= 1'b1;
                     outcome      <= OUT_STALL;
                  end else begin
                     pwm_ratio <= capped_ratio;
                     outcome   <= OUT_CONTINUE;
                  end
                  state <= ST_UPDATE;
               end
               ST_UPDATE: begin
                  pwm_update <= 1'b1;
                  case (outcome)
                     OUT_DONE:  state <= ST_DONE;
                     OUT_STALL: state <= ST_IDLE;
                     default:   state <= ST_WAIT_SAMPLE;
                  endcase
               end
               ST_WAIT_SAMPLE: begin
                  if (i2c_rd_done) begin
                     state <= ST_CALC;
                  end
               end
               ST_DONE: begin
                  angle_done <= 1'b1;
                  state      <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign debug_signals = {pwm_ratio, 1'b0, pwm_done, startup_fail, pwm_direction, state};

endmodule

// File: tb/tb_pid.sv
// Self-checking bench for the PID controller: directed moves plus randomized
// moves, each sample compared against an arithmetic reference model.
module tb_pid;
   import pid_pkg::*;

   localparam int OC_CONT  = 0;
   localparam int OC_DONE  = 1;
   localparam int OC_STALL = 2;

   logic        clock;
   logic        reset;
   logic [11:0] target_angle;
   logic [11:0] current_angle;
   logic        pwm_enable;
   logic        pwm_done;
   logic        i2c_rd_done;
   logic        angle_update;
   logic        abort_angle;
   logic [63:0] profile;
   logic        enable_stall_chk;
   logic [7:0]  kp;
   logic [3:0]  ki;
   logic [3:0]  kd;
   logic        startup_fail;
   logic [15:0] debug_signals;
   logic        angle_done;
   logic        pwm_update;
   logic [7:0]  pwm_ratio;
   logic        pwm_direction;

   int compare_count = 0;
   int fail_count    = 0;

   // Reference model state: one move as the controller should see it.
   int m_target;
   int m_integ;
   int m_prev;
   int m_step;
   int m_run;
   int m_last;
   int prof [8];

   pid dut (
      .clock            (clock),
      .reset            (reset),
      .target_angle     (target_angle),
      .current_angle    (current_angle),
      .pwm_enable       (pwm_enable),
      .pwm_done         (pwm_done),
      .i2c_rd_done      (i2c_rd_done),
      .angle_update     (angle_update),
      .abort_angle      (abort_angle),
      .profile          (profile),
      .enable_stall_chk (enable_stall_chk),
      .kp               (kp),
      .ki               (ki),
      .kd               (kd),
      .startup_fail     (startup_fail),
      .debug_signals    (debug_signals),
      .angle_done       (angle_done),
      .pwm_update       (pwm_update),
      .pwm_ratio        (pwm_ratio),
      .pwm_direction    (pwm_direction)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] kp_v, input logic [3:0] ki_v, input logic [3:0] kd_v, input logic stall_v);
      kp               = kp_v;
      ki               = ki_v;
      kd               = kd_v;
      enable_stall_chk = stall_v;
   endtask

   task automatic setProfile();
      for (int i = 0; i < 8; i++) begin
         profile[63 - 8*i -: 8] = 8'(prof[i]);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // One controller calculation expressed with plain integer arithmetic.
   task automatic modelCalc(input int cur, output int exp_ratio, output int exp_dir, output int exp_outcome);
      int err;
      int pid_val;
      err     = m_target - cur;
      m_integ = m_integ + err;
      if (m_integ > 2047)  m_integ = 2047;
      if (m_integ < -2047) m_integ = -2047;
      pid_val = (int'(kp) * iabs(err)) / 16
              + (int'(ki) * iabs(m_integ)) / 16
              + (int'(kd) * iabs(err - m_prev)) / 16;
      if (pid_val > 255) pid_val = 255;
      if (m_step == 0 || cur != m_last) m_run = 1;
      else m_run++;
      m_last  = cur;
      m_prev  = err;
      exp_dir = (err > 0) ? 1 : 0;
      if (err == 0) begin
         exp_ratio   = 0;
         exp_outcome = OC_DONE;
      end else if (enable_stall_chk && m_step < 8 && m_run >= 8) begin
         exp_ratio   = 0;
         exp_outcome = OC_STALL;
      end else begin
         exp_ratio   = (m_step < 8 && prof[m_step] < pid_val) ? prof[m_step] : pid_val;
         exp_outcome = OC_CONT;
      end
      if (m_step < 8) m_step++;
   endtask

   // Drive one start or sample pulse and check the whole response to it.
   task automatic doSample(input bit is_start, input int cur, output int outcome);
      int er;
      int ed;
      current_angle = 12'(cur);
      if (is_start) angle_update = 1'b1;
      else          i2c_rd_done  = 1'b1;
      @(negedge clock);
      angle_update = 1'b0;
      i2c_rd_done  = 1'b0;
      modelCalc(cur, er, ed, outcome);
      @(negedge clock);
      checkOutput("update_early", pwm_update, 0);
      @(negedge clock);
      checkOutput("update_pulse", pwm_update, 1);
      checkOutput("ratio", pwm_ratio, er);
      checkOutput("direction", pwm_direction, ed);
      checkOutput("debug_ratio", debug_signals[15:8], er);
      if (is_start) checkOutput("fail_cleared", startup_fail, 0);
      if (outcome == OC_DONE) begin
         @(negedge clock);
         checkOutput("done_pulse", angle_done, 1);
         checkOutput("update_single", pwm_update, 0);
         @(negedge clock);
         checkOutput("done_single", angle_done, 0);
         checkOutput("done_idle", debug_signals[3:0], 32'(ST_IDLE));
      end else if (outcome == OC_STALL) begin
         checkOutput("stall_flag", startup_fail, 1);
         @(negedge clock);
         checkOutput("stall_no_done", angle_done, 0);
         checkOutput("stall_idle", debug_signals[3:0], 32'(ST_IDLE));
         checkOutput("stall_ratio", pwm_ratio, 0);
      end else begin
         @(negedge clock);
         checkOutput("wait_state", debug_signals[3:0], 32'(ST_WAIT_SAMPLE));
      end
   endtask

   task automatic startMove(input int tgt, input int cur, output int outcome);
      target_angle = 12'(tgt);
      m_target     = tgt;
      m_integ      = 0;
      m_prev       = 0;
      m_step       = 0;
      m_run        = 0;
      m_last       = cur;
      doSample(1'b1, cur, outcome);
   endtask

   // Abort (or drop the enable) while a sample also arrives; expect one update and IDLE.
   task automatic abortMid(input bit use_enable);
      if (use_enable) pwm_enable = 1'b0;
      else            abort_angle = 1'b1;
      i2c_rd_done = 1'b1;
      @(negedge clock);
      pwm_enable  = 1'b1;
      abort_angle = 1'b0;
      i2c_rd_done = 1'b0;
      checkOutput("abort_update", pwm_update, 1);
      checkOutput("abort_ratio", pwm_ratio, 0);
      checkOutput("abort_idle", debug_signals[3:0], 32'(ST_IDLE));
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput("abort_quiet_update", pwm_update, 0);
         checkOutput("abort_no_done", angle_done, 0);
      end
   endtask

   // A start request mid-move with a new target must be ignored.
   task automatic ignoredStart();
      target_angle = 12'($urandom_range(0, 4095));
      angle_update = 1'b1;
      @(negedge clock);
      angle_update = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("ignored_start", pwm_update, 0);
      checkOutput("ignored_state", debug_signals[3:0], 32'(ST_WAIT_SAMPLE));
   endtask

   // Directed sequence followed by randomized moves.
   initial begin
      int outc;
      int cur;
      int sel;
      bit hold;

      reset            = 1'b1;
      target_angle     = 12'd0;
      current_angle    = 12'd0;
      pwm_enable       = 1'b1;
      pwm_done         = 1'b1;
      i2c_rd_done      = 1'b0;
      angle_update     = 1'b0;
      abort_angle      = 1'b0;
      profile          = 64'd0;
      applyStimulus(8'h08, 4'd0, 4'd0, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_ratio", pwm_ratio, 0);
      checkOutput("reset_update", pwm_update, 0);
      checkOutput("reset_done", angle_done, 0);
      checkOutput("reset_fail", startup_fail, 0);
      checkOutput("reset_dir", pwm_direction, 0);
      checkOutput("reset_debug", debug_signals, 16'h0040);
      pwm_done = 1'b0;
      @(negedge clock);
      checkOutput("debug_pwm_done", debug_signals[6], 0);

      // Start request while disabled is ignored.
      pwm_enable   = 1'b0;
      angle_update = 1'b1;
      target_angle = 12'd100;
      @(negedge clock);
      angle_update = 1'b0;
      pwm_enable   = 1'b1;
      repeat (3) begin
         @(negedge clock);
         checkOutput("disabled_start", pwm_update, 0);
      end
      checkOutput("disabled_idle", debug_signals[3:0], 32'(ST_IDLE));

      // Full forward move with a 2..9 startup profile.
      for (int i = 0; i < 8; i++) prof[i] = i + 2;
      setProfile();
      applyStimulus(8'h08, 4'd0, 4'd0, 1'b0);
      startMove(100, 10, outc);
      checkOutput("first_ratio", pwm_ratio, 2);
      checkOutput("first_dir", pwm_direction, 1);
      for (int i = 1; i <= 90 && outc == OC_CONT; i++) begin
         doSample(1'b0, 10 + i, outc);
         if (i < 8)  checkOutput("profile_step", pwm_ratio, i + 2);
         if (i == 8) checkOutput("uncapped_step", pwm_ratio, 41);
      end
      checkOutput("forward_done", outc, OC_DONE);

      // Reverse move, abort, then restart from step 0.
      startMove(10, 100, outc);
      checkOutput("reverse_dir", pwm_direction, 0);
      checkOutput("reverse_ratio", pwm_ratio, 2);
      doSample(1'b0, 99, outc);
      abortMid(1'b0);
      startMove(10, 98, outc);
      checkOutput("restart_ratio", pwm_ratio, 2);
      abortMid(1'b1);

      // Stall: current held at 10 with the check enabled.
      applyStimulus(8'h08, 4'd0, 4'd0, 1'b1);
      startMove(100, 10, outc);
      for (int i = 1; i < 8 && outc == OC_CONT; i++) doSample(1'b0, 10, outc);
      checkOutput("stall_outcome", outc, OC_STALL);
      checkOutput("stall_sticky", startup_fail, 1);

      // Reset in the middle of a move.
      startMove(200, 10, outc);
      reset       = 1'b1;
      i2c_rd_done = 1'b1;
      @(negedge clock);
      reset       = 1'b0;
      i2c_rd_done = 1'b0;
      checkOutput("midreset_ratio", pwm_ratio, 0);
      checkOutput("midreset_idle", debug_signals[3:0], 32'(ST_IDLE));
      repeat (3) begin
         @(negedge clock);
         checkOutput("midreset_quiet", pwm_update, 0);
         checkOutput("midreset_no_done", angle_done, 0);
      end

      // Randomized moves with random gains, profiles and sample patterns.
      for (int mv = 0; mv < 12; mv++) begin
         for (int b = 0; b < 8; b++) prof[b] = $urandom_range(0, 255);
         setProfile();
         hold = (mv % 3 == 0);
         applyStimulus(8'($urandom), 4'($urandom), 4'($urandom), hold ? 1'b1 : 1'($urandom));
         cur = $urandom_range(0, 4095);
         startMove($urandom_range(0, 4095), cur, outc);
         for (int s = 0; s < 14 && outc == OC_CONT; s++) begin
            if (s == 3) ignoredStart();
            if (!hold) begin
               sel = $urandom_range(0, 5);
               if (sel == 1)      cur = m_target;
               else if (sel == 2) cur = $urandom_range(0, 4095);
               else if (sel > 2)  cur = cur + (m_target - cur) / 2;
            end
            doSample(1'b0, cur, outc);
         end
         if (outc == OC_CONT) abortMid(1'(mv % 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule

// File: doc/pid.md
PID -- requirements
Module: pid

Interface
REQ-001 clock  in  1  sole clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 target_angle  in  12  commanded angle, unsigned encoder counts.
REQ-004 current_angle  in  12  measured angle from encoder.
REQ-005 pwm_enable  in  1  master enable; low forces output off.
REQ-006 pwm_done  in  1  PWM block acknowledge; status only, mirrored to debug.
REQ-007 i2c_rd_done  in  1  one-cycle pulse: current_angle holds a fresh sample.
REQ-008 angle_update  in  1  one-cycle pulse: start a move to target_angle.
REQ-009 abort_angle  in  1  stop the move immediately.
REQ-010 profile  in  64  eight startup ratio caps; byte [63:56] is step 0, [7:0] is step 7.
REQ-011 enable_stall_chk  in  1  enables the startup stall check.
REQ-012 kp  in  8  proportional gain, unsigned fixed 4.4.
REQ-013 ki  in  4  integral gain, unsigned fixed 0.4.
REQ-014 kd  in  4  derivative gain, unsigned fixed 0.4.
REQ-015 startup_fail  out  1  sticky stall error.
REQ-016 debug_signals  out  16  [3:0] state, [4] pwm_direction, [5] startup_fail, [6] pwm_done, [7] 0, [15:8] pwm_ratio.
REQ-017 angle_done  out  1  one-cycle pulse: target reached.
REQ-018 pwm_update  out  1  one-cycle pulse: pwm_ratio/pwm_direction are new.
REQ-019 pwm_ratio  out  8  PWM high time out of 255.
REQ-020 pwm_direction  out  1  1 = error positive (forward), 0 = reverse.

Function
REQ-021 States: IDLE, CALC, UPDATE, WAIT_SAMPLE, DONE.
REQ-022 IDLE -> CALC on angle_update with pwm_enable=1.
- Latch target_angle.
- Clear integral, previous error, step index, stall counter and startup_fail.
- angle_update is ignored when pwm_enable=0.
REQ-023 CALC computes from the latched target and current_angle:
- err = target - current, 13-bit signed.
- P = (kp*|err|)>>4.
- integral += err, saturated to +/-2047; I = (ki*|integral|)>>4.
- D = (kd*|err - prev_err|)>>4.
- out = P+I+D, saturated to 255.
REQ-024 Profile cap: for step index k<8, pwm_ratio = min(out, profile byte k), then k increments; for k>=8, pwm_ratio = out.
REQ-025 pwm_direction = (err > 0).
REQ-026 If err == 0: pwm_ratio = 0 and next state is DONE.
REQ-027 UPDATE asserts pwm_update for exactly one cycle, 2 cycles after the triggering angle_update/i2c_rd_done; then goes to WAIT_SAMPLE (or DONE per REQ-026).
REQ-028 WAIT_SAMPLE -> CALC on i2c_rd_done; prev_err is updated each calculation.
REQ-029 DONE pulses angle_done for one cycle, then returns to IDLE; pwm_ratio stays 0.
REQ-030 Stall check (enable_stall_chk=1, k<8): 8 consecutive samples with unchanged current_angle:
- set startup_fail;
- pwm_ratio = 0 and pulse pwm_update;
- return to IDLE with no angle_done.
REQ-031 abort_angle or pwm_enable=0 in any non-IDLE state: pwm_ratio = 0, one pwm_update pulse, IDLE next cycle, no angle_done.
REQ-032 Precedence: abort and pwm_enable=0 beat i2c_rd_done; angle_update outside IDLE is ignored.
REQ-033 Subtraction is plain 12-bit, with no shortest-path wrap.

Reset
REQ-034 Reset gives:
- state IDLE;
- pwm_ratio, pwm_update, angle_done, startup_fail = 0;
- pwm_direction = 0;
- integral, prev_err, step index, stall counter = 0.
REQ-035 Reset mid-move aborts immediately and no pulses follow.

Structure
REQ-036 A shared package holds:
- state encoding;
- gain fraction shift (4);
- integral limit (2047);
- profile depth (8);
- stall sample limit (8).
REQ-037 Single module; the gain multiply/saturate datapath may be one sub-module, pid_term_calc.

Verification
REQ-038 kp=0x08, ki=kd=0, target=100, current=10, angle_update -> pwm_update with pwm_ratio=2, pwm_direction=1.
REQ-039 Same move, current +1 per i2c_rd_done:
- ratios 2,3,...,9 for steps 0-7;
- step 8 (current=18, err=82) -> 41;
- ratio then decreases monotonically.
REQ-040 Current reaches 100 -> pwm_ratio=0, pwm_update, then one angle_done pulse, state IDLE.
REQ-041 target=10, current=100 -> pwm_direction=0, first ratio 2.
REQ-042 enable_stall_chk=1, current held at 10 for 8 samples -> startup_fail=1, pwm_ratio=0, no angle_done.
REQ-043 abort_angle mid-move -> pwm_ratio=0, one pwm_update, IDLE, no angle_done; a new angle_update restarts from step 0.
